// File: rtl/uart_receiver_with_peripheral_pkg.sv
// rtl/uart_receiver_with_peripheral_pkg.sv - shared deframer states and key bit map
package uart_receiver_with_peripheral_pkg;

  // Deframer states; the transmitter-side encoder walks the same sequence.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Key positions inside the low nibble of a key frame.
  localparam int KEY_A_BIT = 0;
  localparam int KEY_S_BIT = 1;
  localparam int KEY_D_BIT = 2;
  localparam int KEY_W_BIT = 3;
  localparam int KEY_COUNT = 4;

  typedef struct packed {
    logic w;
    logic d;
    logic s;
    logic a;
  } keys_t;

  // Low nibble of a key frame to named key levels.
  function automatic keys_t decode_keys(input logic [KEY_COUNT-1:0] nib);
    keys_t k;
    k.a = nib[KEY_A_BIT];
    k.s = nib[KEY_S_BIT];
    k.d = nib[KEY_D_BIT];
    k.w = nib[KEY_W_BIT];
    return k;
  endfunction

  // Named key levels to the low nibble, used by the encoder side.
  function automatic logic [KEY_COUNT-1:0] encode_keys(input keys_t k);
    logic [KEY_COUNT-1:0] nib;
    nib            = '0;
    nib[KEY_A_BIT] = k.a;
    nib[KEY_S_BIT] = k.s;
    nib[KEY_D_BIT] = k.d;
    nib[KEY_W_BIT] = k.w;
    return nib;
  endfunction

endpackage

// File: rtl/uart_receiver_with_peripheral_uart_receiver.sv
// rtl/uart_receiver_with_peripheral_uart_receiver.sv - 8N1-style serial deframer
module UART_receiver
  import uart_receiver_with_peripheral_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int BIT_COUNTER_WIDTH   = 3,
  parameter int CLOCK_COUNTER_WIDTH = 9,
  parameter int CLOCKS_PER_BIT      = 434
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_RX,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_error
);

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] HALF_BIT =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] FULL_BIT =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT =
    BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  logic                           rx_meta_q;
  logic                           rx_sync_q;
  rx_state_e                      state_q;
  logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt_q;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_idx_q;
  logic [DATA_WIDTH-1:0]          shift_q;
  logic [DATA_WIDTH-1:0]          data_q;
  logic                           valid_q;
  logic                           frame_error_q;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Deframing FSM with registered data, valid and frame-error outputs.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state_q       <= ST_IDLE;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!rx_sync_q) state_q <= ST_START;
        end
        ST_START: begin
          // Mid-start-bit recheck rejects short glitches.
          if (clk_cnt_q == HALF_BIT) begin
            clk_cnt_q <= '0;
            state_q   <= rx_sync_q ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (clk_cnt_q == FULL_BIT) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_q <= '0;
              state_q   <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (clk_cnt_q == FULL_BIT) begin
            clk_cnt_q <= '0;
            if (rx_sync_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= ST_WAIT_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // A low stop bit may be a break; wait for the line to recover.
          clk_cnt_q <= '0;
          if (rx_sync_q) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
        end
      endcase
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = frame_error_q;

endmodule

// File: rtl/uart_receiver_with_peripheral.sv
// rtl/uart_receiver_with_peripheral.sv - UART key receiver with key-hold timeout
module uart_receiver_with_peripheral
  import uart_receiver_with_peripheral_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int BIT_COUNTER_WIDTH   = 3,
  parameter int CLOCK_COUNTER_WIDTH = 9,
  parameter int CLOCKS_PER_BIT      = 434,
  parameter int HOLD_COUNTER_WIDTH  = 22,
  parameter int CLOCKS_FOR_HOLD     = 3217994
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_RX,
  output logic                  o_key_a,
  output logic                  o_key_s,
  output logic                  o_key_d,
  output logic                  o_key_w,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_error
);

  localparam logic [HOLD_COUNTER_WIDTH-1:0] HOLD_LAST =
    HOLD_COUNTER_WIDTH'(CLOCKS_FOR_HOLD - 1);

  logic [DATA_WIDTH-1:0]         rx_data;
  logic                          rx_valid;
  logic                          rx_frame_error;
  logic                          key_frame;
  keys_t                         frame_keys;
  keys_t                         keys_q;
  keys_t                         keys_d;
  keys_t                         keys_view;
  logic [HOLD_COUNTER_WIDTH-1:0] hold_cnt_q;
  logic [HOLD_COUNTER_WIDTH-1:0] hold_cnt_d;

  UART_receiver #(
    .DATA_WIDTH         (DATA_WIDTH),
    .BIT_COUNTER_WIDTH  (BIT_COUNTER_WIDTH),
    .CLOCK_COUNTER_WIDTH(CLOCK_COUNTER_WIDTH),
    .CLOCKS_PER_BIT     (CLOCKS_PER_BIT)
  ) u_rx (
    .i_clock      (i_clock),
    .i_resetL     (i_resetL),
    .i_RX         (i_RX),
    .o_data       (rx_data),
    .o_valid      (rx_valid),
    .o_frame_error(rx_frame_error)
  );

  // Only frames with an empty upper field carry key state.
  assign key_frame  = rx_valid && (rx_data[DATA_WIDTH-1:KEY_COUNT] == '0);
  assign frame_keys = decode_keys(rx_data[KEY_COUNT-1:0]);

  // Next key state: a new key frame beats a same-cycle timeout.
  always_comb begin
    keys_d     = keys_q;
    hold_cnt_d = hold_cnt_q;
    if (key_frame) begin
      keys_d     = frame_keys;
      hold_cnt_d = '0;
    end else if (keys_q != '0) begin
      if (hold_cnt_q == HOLD_LAST) begin
        keys_d     = '0;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  // Key levels and hold timer; the timer idles while no key is held.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      keys_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      keys_q     <= keys_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Keys show the new frame in the same cycle the valid pulse is high.
  assign keys_view = key_frame ? frame_keys : keys_q;

  assign o_key_a       = keys_view.a;
  assign o_key_s       = keys_view.s;
  assign o_key_d       = keys_view.d;
  assign o_key_w       = keys_view.w;
  assign o_data        = rx_data;
  assign o_valid       = rx_valid;
  assign o_frame_error = rx_frame_error;

endmodule

// File: tb/tb_uart_receiver_with_peripheral.sv
// tb/tb_uart_receiver_with_peripheral.sv - directed bench for the UART key receiver
module tb_uart_receiver_with_peripheral;

  localparam int CPB  = 434;
  localparam int HOLD = 5000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       key_a, key_s, key_d, key_w;
  logic [7:0] data;
  logic       valid;
  logic       ferr;

  int         cyc = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         valid_cyc = 0;
  logic [3:0] ferr_keys = 4'h0;
  int         passed = 0;
  int         total = 0;
  int         start_cyc = 0;
  int         v0, f0, tv, tv2, lat, tv3;

  always #5 clk = ~clk;

  uart_receiver_with_peripheral #(
    .CLOCKS_PER_BIT (CPB),
    .CLOCKS_FOR_HOLD(HOLD)
  ) dut (
    .i_clock      (clk),
    .i_resetL     (rst_n),
    .i_RX         (rx),
    .o_key_a      (key_a),
    .o_key_s      (key_s),
    .o_key_d      (key_d),
    .o_key_w      (key_w),
    .o_data       (data),
    .o_valid      (valid),
    .o_frame_error(ferr)
  );

  // Event monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (ferr === 1'b1) begin
      ferr_cnt  = ferr_cnt + 1;
      ferr_keys = {key_w, key_d, key_s, key_a};
    end
    cyc = cyc + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] keys();
    return {28'h0, key_w, key_d, key_s, key_a};
  endfunction

  // One frame; low_stop > 0 holds the stop bit low for that many bit times.
  task automatic send(input logic [7:0] d, input int low_stop);
    rx        = 1'b0;
    start_cyc = cyc;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(CPB);
    end
    if (low_stop > 0) begin
      rx = 1'b0;
      wait_cycles(low_stop * CPB);
    end
    rx = 1'b1;
    wait_cycles(CPB);
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    wait_cycles(5);
    check("reset_data",  32'(data),  32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_ferr",  32'(ferr),  32'h0);
    check("reset_keys",  keys(),     32'h0);
    rst_n = 1'b1;
    wait_cycles(20);

    // 0x05 -> keys a and d
    v0 = valid_cnt;
    send(8'h05, 0);
    check("k05_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("k05_data",      32'(data),           32'h05);
    check("k05_keys",      keys(),              32'h5);

    // 100-cycle glitch is rejected
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_cycles(100);
    rx = 1'b1;
    wait_cycles(200);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_ferr",  32'(ferr_cnt - f0),  32'd0);

    // 0x08 with stop held low for two bits
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send(8'h08, 2);
    check("ferr_cnt",       32'(ferr_cnt - f0),  32'd1);
    check("ferr_valid",     32'(valid_cnt - v0), 32'd0);
    check("ferr_data",      32'(data),           32'h05);
    check("ferr_keys_held", 32'(ferr_keys),      32'h5);
    check("ferr_no_w",      32'(key_w),          32'h0);
    wait_cycles(CPB);

    send(8'h02, 0);
    check("k02_data", 32'(data), 32'h02);
    check("k02_keys", keys(),    32'h2);

    // 0x01 then idle: key a holds, then times out
    send(8'h01, 0);
    tv = valid_cyc;
    check("k01_keys", keys(), 32'h1);
    wait_until(tv + HOLD - 5);
    check("hold_before_timeout", 32'(key_a), 32'h1);
    wait_until(tv + HOLD + 5);
    check("hold_after_timeout",  32'(key_a), 32'h0);

    // Refresh landing at cycle 4999 keeps key a held
    send(8'h01, 0);
    tv2 = valid_cyc;
    lat = tv2 - start_cyc;
    wait_until(tv2 + HOLD - 1 - lat);
    send(8'h01, 0);
    tv3 = valid_cyc;
    check("refresh_landed", 32'(tv3 - tv2), 32'(HOLD - 1));
    check("refresh_keeps_a", keys(), 32'h1);

    // 0x80 updates data but not keys or the hold timer
    v0 = valid_cnt;
    send(8'h80, 0);
    check("k80_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("k80_data",      32'(data),           32'h80);
    check("k80_keys",      keys(),              32'h1);
    wait_until(tv3 + HOLD - 5);
    check("k80_hold_before", 32'(key_a), 32'h1);
    wait_until(tv3 + HOLD + 5);
    check("k80_no_restart",  32'(key_a), 32'h0);

    // Reset during data bit 4, rest of the frame stays high
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_cycles(CPB);
    rx = 1'b1; wait_cycles(CPB);
    rx = 1'b1; wait_cycles(CPB);
    rx = 1'b0; wait_cycles(CPB);
    rx = 1'b0; wait_cycles(CPB);
    rx = 1'b1;
    wait_cycles(200);
    rst_n = 1'b0;
    #1;
    check("midrst_data",  32'(data),  32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_ferr",  32'(ferr),  32'h0);
    check("midrst_keys",  keys(),     32'h0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(234 + 4 * CPB);
    check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("midrst_no_ferr",  32'(ferr_cnt - f0),  32'd0);

    send(8'h0F, 0);
    check("k0f_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("k0f_data",      32'(data),           32'h0F);
    check("k0f_keys",      keys(),              32'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
